// File: rtl/reset_pkg.sv
// rtl/reset_pkg.sv - shared types, default timing constants and counter sizing for the reset sequencer
package reset_pkg;

  typedef enum logic [1:0] {HOLD, WAIT, GAP, RUN} seq_state_t;

  localparam int CLK_HZ         = 10_000_000;
  localparam int MIN_ASSERT     = 1000;
  localparam int GAP_CYCLES     = 100;
  localparam int TIMEOUT_CYCLES = 1_000_000;

  // Bits needed to hold the largest of the three cycle counts.
  function automatic int counter_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_timer.sv
// rtl/reset_timer.sv - clearable up-counter with a terminal compare, shared by every sequencer state
module reset_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] target,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Saturates instead of wrapping so a stalled state can never alias a short count.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign done = (count == target);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases per-subsystem resets in order, gated by ready acknowledges or timeouts
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int MIN_ASSERT     = reset_pkg::MIN_ASSERT,
  parameter int GAP_CYCLES     = reset_pkg::GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = reset_pkg::TIMEOUT_CYCLES,
  localparam int SW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  sys_ready,
  output logic [NUM_STAGES-1:0] fault,
  output logic [SW-1:0]         cur_stage
);

  import reset_pkg::*;

  localparam int CW = reset_pkg::counter_width(MIN_ASSERT, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  seq_state_t            state, next_state;
  logic [SW-1:0]         next_stage;
  logic [NUM_STAGES-1:0] fault_set;
  logic [CW-1:0]         tmr_target;
  logic                  tmr_en, tmr_done, advance;

  reset_timer #(.WIDTH(CW)) u_timer (
    .clk    (clk),
    .clr    (reset | soft_req | advance),
    .en     (tmr_en),
    .target (tmr_target),
    .done   (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HOLD;
      cur_stage <= '0;
      fault     <= '0;
    end else if (soft_req) begin
      state     <= HOLD;
      cur_stage <= '0;
    end else begin
      state     <= next_state;
      cur_stage <= next_stage;
      fault     <= fault | fault_set;
    end
  end

  always_comb begin
    next_state = state;
    next_stage = cur_stage;
    fault_set  = '0;
    tmr_target = '0;
    tmr_en     = 1'b0;
    advance    = 1'b0;
    case (state)
      HOLD: begin
        tmr_target = HOLD_LAST;
        tmr_en     = 1'b1;
        if (tmr_done) begin
          advance    = 1'b1;
          next_state = WAIT;
          next_stage = '0;
        end
      end
      WAIT: begin
        tmr_target = WAIT_LAST;
        tmr_en     = 1'b1;
        if (stage_ready[cur_stage] || tmr_done) begin
          advance = 1'b1;
          if (!stage_ready[cur_stage]) fault_set[cur_stage] = 1'b1;
          // With no settle gap the next stage goes on the same edge that saw ready.
          if (GAP_CYCLES > 0) begin
            next_state = GAP;
          end else if (cur_stage == LAST_STAGE) begin
            next_state = RUN;
          end else begin
            next_state = WAIT;
            next_stage = cur_stage + SW'(1);
          end
        end
      end
      GAP: begin
        tmr_target = GAP_LAST;
        tmr_en     = 1'b1;
        if (tmr_done) begin
          advance = 1'b1;
          if (cur_stage == LAST_STAGE) begin
            next_state = RUN;
          end else begin
            next_state = WAIT;
            next_stage = cur_stage + SW'(1);
          end
        end
      end
      RUN: begin
        next_state = RUN;
      end
    endcase
  end

  // Stage resets are a pure function of state and index, so releases stay monotonic.
  always_comb begin
    stage_reset = '1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      case (state)
        HOLD:      stage_reset[i] = 1'b1;
        WAIT, GAP: stage_reset[i] = (SW'(i) > cur_stage);
        RUN:       stage_reset[i] = 1'b0;
      endcase
    end
  end

  assign sys_ready = (state == RUN);

endmodule
